btpipe_block_arbiter: RTL and testbench

Shares one Block-Throttled Pipe Out endpoint between N_CH producer channels. Each channel supplies a first-word-fall-through FIFO data word and a fill level.
The arbiter grants whole blocks to eligible channels in round-robin order. It drives the endpoint's ep_ready and ep_datain, and steers host reads to the granted channel's FIFO.
It sits on the user side of the block pipe-out endpoint, between that endpoint and the per-channel capture FIFOs.

---
 rtl/btpipe_block_arbiter_if.sv | 22 ++
 rtl/btpipe_block_arbiter.sv | 139 +++++++++++++
 tb/tb_btpipe_block_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/btpipe_block_arbiter_if.sv
// Block-throttled pipe-out endpoint handshake shared between the host endpoint
// (master) and the channel arbiter (slave).
interface btpipe_block_arbiter_if;
    logic        ep_read;
    logic        ep_blockstrobe;
    logic        ep_ready;
    logic [15:0] ep_datain;

    modport master (
        output ep_read,
        output ep_blockstrobe,
        input  ep_ready,
        input  ep_datain
    );

    modport slave (
        input  ep_read,
        input  ep_blockstrobe,
        output ep_ready,
        output ep_datain
    );
endinterface

// File: rtl/btpipe_block_arbiter.sv
// Round-robin arbiter granting whole host blocks of one pipe-out endpoint to
// N_CH FWFT producer FIFOs; flags host protocol violations in a sticky bit.
module btpipe_block_arbiter #(
    parameter int N_CH        = 4,
    parameter int BLOCK_WORDS = 256,
    parameter int LVL_W       = 16,
    parameter int GNT_W       = 2
) (
    input  logic                    ti_clk,
    input  logic                    rst_n,
    btpipe_block_arbiter_if.slave   ep,
    input  logic [N_CH-1:0]         ch_enable,
    input  logic [N_CH*LVL_W-1:0]   ch_level,
    input  logic [N_CH*16-1:0]      ch_data,
    output logic [N_CH-1:0]         ch_rd,
    output logic [GNT_W-1:0]        grant,
    output logic                    busy,
    output logic                    proto_err,
    input  logic                    err_clr
);

    localparam int CNT_W = (BLOCK_WORDS > 2) ? $clog2(BLOCK_WORDS) : 1;
    localparam int CMP_W = ((LVL_W > 32) ? LVL_W : 32) + 1;
    localparam logic [CMP_W-1:0] BLOCK_THRESH = CMP_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD    = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        XFER  = 2'd2
    } state_e;

    state_e             state_q;
    logic [GNT_W-1:0]   grant_q;
    logic [GNT_W-1:0]   rrPtr_q;
    logic [CNT_W-1:0]   wordCnt_q;
    logic               epReady_q;
    logic               busy_q;
    logic               protoErr_q;

    logic [N_CH-1:0]    eligible;
    logic               pickValid_d;
    logic [GNT_W-1:0]   pickIdx_d;
    logic               newErr_d;
    logic               protoErr_d;

    // Level compare is done zero-extended so any LVL_W works against BLOCK_WORDS.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_CH; i++) begin
            eligible[i] = ch_enable[i] &&
                ({{(CMP_W-LVL_W){1'b0}}, ch_level[i*LVL_W +: LVL_W]} >= BLOCK_THRESH);
        end
    end

    always_comb begin
        pickValid_d = 1'b0;
        pickIdx_d   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            if (!pickValid_d && eligible[(int'(rrPtr_q) + k) % N_CH]) begin
                pickValid_d = 1'b1;
                pickIdx_d   = GNT_W'((int'(rrPtr_q) + k) % N_CH);
            end
        end
    end

    always_comb begin
        newErr_d   = ((state_q != XFER)  && ep.ep_read) ||
                     ((state_q != ARMED) && ep.ep_blockstrobe);
        protoErr_d = (protoErr_q && !err_clr) || newErr_d;
    end

    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rrPtr_q    <= GNT_W'(N_CH - 1);
            wordCnt_q  <= '0;
            epReady_q  <= 1'b0;
            busy_q     <= 1'b0;
            protoErr_q <= 1'b0;
        end else begin
            protoErr_q <= protoErr_d;
            case (state_q)
                IDLE: begin
                    if (pickValid_d) begin
                        grant_q   <= pickIdx_d;
                        epReady_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ARMED;
                    end
                end
                ARMED: begin
                    // A block start wins over the granted channel losing eligibility.
                    if (ep.ep_blockstrobe) begin
                        epReady_q <= 1'b0;
                        wordCnt_q <= '0;
                        state_q   <= XFER;
                    end else if (!eligible[grant_q]) begin
                        epReady_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                XFER: begin
                    if (ep.ep_read) begin
                        if (wordCnt_q == LAST_WORD) begin
                            rrPtr_q   <= grant_q;
                            wordCnt_q <= '0;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            wordCnt_q <= wordCnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    epReady_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ch_rd = '0;
        if ((state_q == XFER) && ep.ep_read) begin
            ch_rd[grant_q] = 1'b1;
        end
    end

    assign ep.ep_ready  = epReady_q;
    assign ep.ep_datain = ch_data[32'(grant_q) * 16 +: 16];
    assign grant        = grant_q;
    assign busy         = busy_q;
    assign proto_err    = protoErr_q;

endmodule

// File: tb/tb_btpipe_block_arbiter.sv
// Directed bench for btpipe_block_arbiter: a per-cycle vector table followed by
// full-block sequences (single channel, round-robin, reset mid-block).
module tb_btpipe_block_arbiter;

    logic              tiClk;
    logic              rstN;
    logic [3:0]        chEnable;
    logic [3:0][15:0]  chLevel;
    logic [3:0][15:0]  chData;
    logic [3:0]        chRd;
    logic [1:0]        grant;
    logic              busy;
    logic              protoErr;
    logic              errClr;

    int compareCount = 0;
    int failCount    = 0;

    btpipe_block_arbiter_if epIf ();

    btpipe_block_arbiter #(
        .N_CH(4), .BLOCK_WORDS(256), .LVL_W(16), .GNT_W(2)
    ) dut (
        .ti_clk    (tiClk),
        .rst_n     (rstN),
        .ep        (epIf),
        .ch_enable (chEnable),
        .ch_level  (chLevel),
        .ch_data   (chData),
        .ch_rd     (chRd),
        .grant     (grant),
        .busy      (busy),
        .proto_err (protoErr),
        .err_clr   (errClr)
    );

    initial tiClk = 1'b0;
    always #5 tiClk = ~tiClk;

    typedef struct {
        logic [3:0]       en;
        logic [3:0][15:0] lvl;
        logic             rd;
        logic             strobe;
        logic             clr;
        logic [3:0]       expRd;
        logic             expReady;
        logic [1:0]       expGrant;
        logic             expBusy;
        logic             expErr;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic [3:0] en, input int l0, input int l1, input int l2,
                          input int l3, input logic rd, input logic strobe, input logic clr,
                          input logic [3:0] expRd, input logic expReady,
                          input logic [1:0] expGrant, input logic expBusy, input logic expErr);
        vec_t v;
        v.en       = en;
        v.lvl[0]   = 16'(l0);
        v.lvl[1]   = 16'(l1);
        v.lvl[2]   = 16'(l2);
        v.lvl[3]   = 16'(l3);
        v.rd       = rd;
        v.strobe   = strobe;
        v.clr      = clr;
        v.expRd    = expRd;
        v.expReady = expReady;
        v.expGrant = expGrant;
        v.expBusy  = expBusy;
        v.expErr   = expErr;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compareCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        chEnable            = v.en;
        chLevel             = v.lvl;
        epIf.ep_read        = v.rd;
        epIf.ep_blockstrobe = v.strobe;
        errClr              = v.clr;
    endtask

    task automatic resetDut();
        rstN                = 1'b0;
        chEnable            = '0;
        chLevel             = '0;
        epIf.ep_read        = 1'b0;
        epIf.ep_blockstrobe = 1'b0;
        errClr              = 1'b0;
        repeat (2) @(posedge tiClk);
        #1;
        rstN = 1'b1;
    endtask

    task automatic waitReady();
        for (int c = 0; c < 8 && !epIf.ep_ready; c++) begin
            @(posedge tiClk); #1;
        end
        checkOutput("armReady", 32'(epIf.ep_ready), 32'd1);
    endtask

    task automatic pulseStrobe();
        epIf.ep_blockstrobe = 1'b1;
        @(posedge tiClk); #1;
        epIf.ep_blockstrobe = 1'b0;
        checkOutput("strobeReady", 32'(epIf.ep_ready), 32'd0);
        checkOutput("strobeBusy", 32'(busy), 32'd1);
    endtask

    // Reads n words from channel ch, tallying pops, stray pops and data tracking.
    task automatic doReads(input int n, input int ch);
        int pops;
        int stray;
        int badData;
        pops = 0; stray = 0; badData = 0;
        for (int w = 0; w < n; w++) begin
            chData[ch]   = 16'((ch << 12) | (w & 12'hFFF));
            epIf.ep_read = 1'b1;
            #1;
            if (chRd[ch]) pops++;
            if ((chRd & ~(4'b0001 << ch)) != 4'b0000) stray++;
            if (epIf.ep_datain !== chData[ch]) badData++;
            @(posedge tiClk); #1;
        end
        epIf.ep_read = 1'b0;
        checkOutput("blockPops", 32'(pops), 32'(n));
        checkOutput("strayRd", 32'(stray), 32'd0);
        checkOutput("dataTrack", 32'(badData), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) chData[i] = 16'hA000 | 16'(i << 8);

        //      en      l0   l1   l2   l3 rd st cl  expRd  rdy gnt bsy err
        addVec(4'b0000,   0,   0,   0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        addVec(4'b0000,   0,   0,   0, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 1);
        addVec(4'b0000,   0,   0,   0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0);
        addVec(4'b0000,   0,   0,   0, 0, 0, 1, 0, 4'b0000, 0, 0, 0, 1);
        addVec(4'b0000,   0,   0,   0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0);
        addVec(4'b0100,   0,   0, 255, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        addVec(4'b0100,   0,   0, 256, 0, 0, 0, 0, 4'b0000, 1, 2, 1, 0);
        addVec(4'b0100,   0,   0, 256, 0, 0, 0, 0, 4'b0000, 1, 2, 1, 0);
        addVec(4'b0100,   0,   0, 256, 0, 1, 0, 0, 4'b0000, 1, 2, 1, 1);
        addVec(4'b0100,   0,   0, 256, 0, 0, 0, 1, 4'b0000, 1, 2, 1, 0);
        addVec(4'b0100,   0,   0, 256, 0, 1, 0, 1, 4'b0000, 1, 2, 1, 1);
        addVec(4'b0100,   0,   0, 256, 0, 0, 0, 1, 4'b0000, 1, 2, 1, 0);
        addVec(4'b0100,   0,   0, 255, 0, 0, 0, 0, 4'b0000, 0, 2, 0, 0);
        addVec(4'b0010,   0, 256,   0, 0, 0, 0, 0, 4'b0000, 1, 1, 1, 0);
        addVec(4'b0000,   0, 256,   0, 0, 0, 0, 0, 4'b0000, 0, 1, 0, 0);
        addVec(4'b0110,   0, 256, 300, 0, 0, 0, 0, 4'b0000, 1, 1, 1, 0);
        addVec(4'b0110,   0, 256, 300, 0, 0, 1, 0, 4'b0000, 0, 1, 1, 0);
        addVec(4'b0110,   0, 256, 300, 0, 0, 1, 0, 4'b0000, 0, 1, 1, 1);
        addVec(4'b0110,   0, 256, 300, 0, 1, 0, 0, 4'b0010, 0, 1, 1, 1);

        resetDut();
        checkOutput("rstReady", 32'(epIf.ep_ready), 32'd0);
        checkOutput("rstGrant", 32'(grant), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstErr", 32'(protoErr), 32'd0);
        checkOutput("rstRd", 32'(chRd), 32'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_rd", i), 32'(chRd), 32'(vecs[i].expRd));
            @(posedge tiClk); #1;
            checkOutput($sformatf("vec%0d_ready", i), 32'(epIf.ep_ready), 32'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].expGrant));
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].expBusy));
            checkOutput($sformatf("vec%0d_err", i), 32'(protoErr), 32'(vecs[i].expErr));
        end

        // Finish the ch1 block: 255 more reads means the stray strobe did not move word_cnt.
        epIf.ep_read = 1'b0;
        doReads(255, 1);
        checkOutput("gapBusy", 32'(busy), 32'd0);
        checkOutput("gapReady", 32'(epIf.ep_ready), 32'd0);
        checkOutput("stickyErr", 32'(protoErr), 32'd1);
        @(posedge tiClk); #1;
        checkOutput("rrNextReady", 32'(epIf.ep_ready), 32'd1);
        checkOutput("rrNextGrant", 32'(grant), 32'd2);
        errClr = 1'b1;
        @(posedge tiClk); #1;
        errClr = 1'b0;
        checkOutput("errCleared", 32'(protoErr), 32'd0);

        // Single channel 0 full block.
        resetDut();
        chEnable   = 4'b0001;
        chLevel[0] = 16'd256;
        @(posedge tiClk); #1;
        checkOutput("ch0Ready", 32'(epIf.ep_ready), 32'd1);
        checkOutput("ch0Grant", 32'(grant), 32'd0);
        pulseStrobe();
        doReads(256, 0);
        checkOutput("ch0DoneBusy", 32'(busy), 32'd0);
        checkOutput("ch0DoneErr", 32'(protoErr), 32'd0);

        // All channels eligible: eight blocks in round-robin order.
        resetDut();
        chEnable = 4'b1111;
        for (int i = 0; i < 4; i++) chLevel[i] = 16'd256;
        for (int b = 0; b < 8; b++) begin
            waitReady();
            checkOutput($sformatf("rrGrant%0d", b), 32'(grant), 32'(b % 4));
            pulseStrobe();
            doReads(256, b % 4);
            checkOutput($sformatf("rrGap%0d", b), 32'(busy), 32'd0);
        end
        checkOutput("rrErr", 32'(protoErr), 32'd0);

        // Reset asserted at word 100 of a block, then a fresh full block.
        resetDut();
        chEnable   = 4'b0001;
        chLevel[0] = 16'd256;
        waitReady();
        pulseStrobe();
        doReads(100, 0);
        epIf.ep_read = 1'b1;
        rstN         = 1'b0;
        #1;
        checkOutput("midRstRd", 32'(chRd), 32'd0);
        checkOutput("midRstReady", 32'(epIf.ep_ready), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstGrant", 32'(grant), 32'd0);
        epIf.ep_read = 1'b0;
        @(posedge tiClk); #1;
        rstN = 1'b1;
        waitReady();
        pulseStrobe();
        doReads(256, 0);
        checkOutput("postRstBusy", 32'(busy), 32'd0);
        checkOutput("postRstErr", 32'(protoErr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
